// File: rtl/inv_sqrt_pkg.sv
// inv_sqrt_pkg: shared state encoding and constants for the inverse-sqrt Newton refinement stage
package inv_sqrt_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SQ   = 3'd1;
    localparam logic [2:0] MXY  = 3'd2;
    localparam logic [2:0] SUB  = 3'd3;
    localparam logic [2:0] MUL  = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;

    localparam int ITER_W = 3;

    // 1.5 in a fixed-point format with frac_w fractional bits
    function automatic logic [31:0] three_halves(input int frac_w);
        return 32'(3) << (frac_w - 1);
    endfunction

endpackage

// File: rtl/inv_sqrt_newton_refine_mul.sv
// fxp_mul_sat: unsigned fixed-point a*b >> FRAC_W, floor-truncated, saturating to all-ones
module fxp_mul_sat #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p,
    output logic              sat
);

    logic [2*DATA_W-1:0] full;
    logic [2*DATA_W-1:0] shifted;

    assign full    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign shifted = full >> FRAC_W;
    assign sat     = |shifted[2*DATA_W-1:DATA_W];
    assign p       = sat ? '1 : shifted[DATA_W-1:0];

endmodule

// File: rtl/inv_sqrt_newton_refine.sv
// inv_sqrt_newton_refine: Newton-Raphson refinement of a 1/sqrt(x) estimate over one shared multiplier
module inv_sqrt_newton_refine
    import inv_sqrt_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ITERS  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] est_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              sat_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              busy
);

    if (ITERS < 0 || ITERS > 7) begin : g_bad_iters
        $error("inv_sqrt_newton_refine: ITERS must be within 0..7");
    end

    localparam logic [DATA_W-1:0] HALF3 = DATA_W'(three_halves(FRAC_W));

    logic [2:0]        state;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] t;
    logic [ITER_W-1:0] iter;
    logic              sat;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_p;
    logic              mul_sat;
    logic [DATA_W-1:0] half_t;
    logic              sub_neg;

    // SQ squares y, MXY scales by x, MUL multiplies y by the correction term
    assign mul_a = (state == MXY) ? x : y;
    assign mul_b = (state == SQ) ? y : t;

    fxp_mul_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .sat (mul_sat)
    );

    assign half_t    = t >> 1;
    assign sub_neg   = half_t > HALF3;
    assign ready_in  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign valid_out = (state == OUT);
    assign sat_out   = valid_out & sat;

    // sequencer and datapath registers; flush aborts but leaves data_out holding the last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            t        <= '0;
            iter     <= '0;
            sat      <= 1'b0;
            data_out <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    x    <= data_in;
                    y    <= est_in;
                    sat  <= 1'b0;
                    iter <= '0;
                    if (ITERS == 0) begin
                        data_out <= est_in;
                        state    <= OUT;
                    end else begin
                        state <= SQ;
                    end
                end
                SQ: begin
                    t     <= mul_p;
                    sat   <= sat | mul_sat;
                    state <= MXY;
                end
                MXY: begin
                    t     <= mul_p;
                    sat   <= sat | mul_sat;
                    state <= SUB;
                end
                SUB: begin
                    t     <= sub_neg ? '0 : HALF3 - half_t;
                    sat   <= sat | sub_neg;
                    state <= MUL;
                end
                MUL: begin
                    y    <= mul_p;
                    sat  <= sat | mul_sat;
                    iter <= iter + 1'b1;
                    if (iter == ITER_W'(ITERS - 1)) begin
                        data_out <= mul_p;
                        state    <= OUT;
                    end else begin
                        state <= SQ;
                    end
                end
                OUT: if (ready_out) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sqrt_newton_refine.sv
// tb_inv_sqrt_newton_refine: scoreboard bench for the Newton refinement stage
module tb_inv_sqrt_newton_refine;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int ITERS  = 2;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] est_in;
    logic              valid_in;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic              sat_out;
    logic              valid_out;
    logic              ready_out;
    logic              busy;

    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W:0]   exp_e;
    logic [DATA_W-1:0] last_data;
    int                n_chk;
    int                n_pass;

    inv_sqrt_newton_refine #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ITERS(ITERS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .data_in   (data_in),
        .est_in    (est_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .sat_out   (sat_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // behavioural Newton model: returns {sat, y}
    function automatic logic [DATA_W:0] model(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] yv);
        longint x = longint'(xv);
        longint y = longint'(yv);
        longint t;
        longint mx = (longint'(1) << DATA_W) - 1;
        bit s = 1'b0;
        for (int i = 0; i < ITERS; i++) begin
            t = (y * y) >> FRAC_W;
            if (t > mx) begin t = mx; s = 1'b1; end
            t = (x * t) >> FRAC_W;
            if (t > mx) begin t = mx; s = 1'b1; end
            t = (longint'(3) << (FRAC_W - 1)) - t / 2;
            if (t < 0) begin t = 0; s = 1'b1; end
            y = (y * t) >> FRAC_W;
            if (y > mx) begin y = mx; s = 1'b1; end
        end
        return {s, y[DATA_W-1:0]};
    endfunction

    // pop the expected result on every completed transfer
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) begin
            if (exp_q.size() == 0) chk("spurious_out", 32'(valid_out), 32'd0);
            else begin
                exp_e = exp_q.pop_front();
                chk("result", 32'({sat_out, data_out}), 32'(exp_e));
            end
        end
    end

    // called at posedge+1; waits for ready_in then presents one job, returns at accept-edge+1
    task automatic start_job(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] yv, input bit push, output int waited);
        logic [DATA_W:0] m;
        waited = 0;
        while (!ready_in && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 100) chk("ready_in_wait", 32'(ready_in), 32'd1);
        data_in  = xv;
        est_in   = yv;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        if (push) begin
            m = model(xv, yv);
            exp_q.push_back(m);
            last_data = m[DATA_W-1:0];
        end
    endtask

    // full job; hold>0 keeps ready_out low that many cycles after valid_out (caller lowered it)
    task automatic run_job(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] yv, input int exp_d, input int hold);
        int w;
        int lat;
        bit ok;
        logic [DATA_W-1:0] d;
        start_job(xv, yv, 1'b1, w);
        for (lat = 1; lat < 100; lat++) begin
            @(negedge clk);
            if (valid_out) break;
            @(posedge clk);
        end
        chk("latency", 32'(lat), 32'(4 * ITERS + 1));
        chk("ready_in_busy", 32'(ready_in), 32'd0);
        if (exp_d >= 0) chk("spec_data", 32'(data_out), 32'(exp_d));
        if (hold > 0) begin
            ok = 1'b1;
            d  = data_out;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                ok &= valid_out && (data_out == d) && !ready_in;
            end
            chk("bp_stable", 32'(ok), 32'd1);
            @(posedge clk);
            #1;
            ready_out = 1'b1;
        end else begin
            for (int i = 0; i < 100 && valid_out; i++) @(negedge clk);
            chk("ready_after_xfer", 32'(ready_in), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int w;
        bit seen;
        n_chk     = 0;
        n_pass    = 0;
        last_data = '0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        est_in    = '0;
        ready_out = 1'b1;
        #2;
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sat", 32'(sat_out), 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(ready_in), 32'd1);

        run_job(16'h0400, 16'h0080, 32'h0080, 0);
        run_job(16'h0400, 16'h0070, 32'h007F, 0);
        run_job(16'hFFFF, 16'h0100, 32'h0000, 0);
        run_job(16'h0100, 16'hFFFF, -1, 0);
        run_job(16'h0000, 16'h0100, -1, 0);

        ready_out = 1'b0;
        run_job(16'h0400, 16'h0080, 32'h0080, 20);
        start_job(16'h0400, 16'h0070, 1'b1, w);
        chk("accept_next_cycle", 32'(w), 32'd1);
        for (int i = 0; i < 100 && !valid_out; i++) @(negedge clk);
        for (int i = 0; i < 100 && valid_out; i++) @(negedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            run_job(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'h0400)), -1, 0);

        start_job(16'h0400, 16'h0080, 1'b0, w);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_sat", 32'(sat_out), 32'd0);
        chk("flush_data_kept", 32'(data_out), 32'(last_data));
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= valid_out;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        valid_in = 1'b0;
        chk("flush_blocks_accept", 32'(busy), 32'd0);

        start_job(16'h0400, 16'h0070, 1'b0, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_data", 32'(data_out), 32'd0);
        chk("abort_valid", 32'(valid_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sat", 32'(sat_out), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(16'h0400, 16'h0080, 32'h0080, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
